// File: rtl/mult_accumulator_pkg.sv
// Shared types and constants for the multiply-accumulate block.
package mult_accumulator_pkg;

  localparam int unsigned OPND_W = 2;
  localparam int unsigned PROD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : mult_accumulator_pkg

// File: rtl/mult_accumulator_if.sv
// Operand stream plus result/status bundle between a producer and the accumulator.
interface mult_accumulator_if #(
  parameter int unsigned ACC_W = 8
);
  import mult_accumulator_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] a;
  logic [OPND_W-1:0] b;
  logic [ACC_W-1:0]  acc;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output start, in_valid, a, b,
    input  in_ready, acc, busy, done, overflow
  );

  modport slave (
    input  start, in_valid, a, b,
    output in_ready, acc, busy, done, overflow
  );

endinterface : mult_accumulator_if

// File: rtl/mult_accumulator_mult.sv
// 2x2 unsigned combinational multiplier (the existing multiplyModule datapath).
module mult_accumulator_mult
  import mult_accumulator_pkg::*;
(
  input  logic [OPND_W-1:0] i_a,
  input  logic [OPND_W-1:0] i_b,
  output logic [PROD_W-1:0] o_p
);

  logic w_a0b0;
  logic w_a1b0;
  logic w_a0b1;
  logic w_a1b1;
  logic w_c1;

  assign w_a0b0 = i_a[0] & i_b[0];
  assign w_a1b0 = i_a[1] & i_b[0];
  assign w_a0b1 = i_a[0] & i_b[1];
  assign w_a1b1 = i_a[1] & i_b[1];
  // Carry from the middle partial-product column feeds bits 2 and 3.
  assign w_c1   = w_a1b0 & w_a0b1;

  assign o_p = {w_a1b1 & w_c1, w_a1b1 ^ w_c1, w_a1b0 ^ w_a0b1, w_a0b0};

endmodule : mult_accumulator_mult

// File: rtl/mult_accumulator.sv
// Accumulates N_TERMS 2x2 products from a valid/ready stream into a dot product.
module mult_accumulator
  import mult_accumulator_pkg::*;
#(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_accumulator_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
  localparam int unsigned SUM_W = ACC_W + 1;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_overflow_nxt;
  logic               w_in_ready;
  logic               w_beat;
  logic               w_last;
  logic [PROD_W-1:0]  w_prod;
  logic [SUM_W-1:0]   w_sum;

  mult_accumulator_mult u_mult (
    .i_a (bus.a),
    .i_b (bus.b),
    .o_p (w_prod)
  );

  assign w_in_ready = (r_state == ST_ACCUM);
  assign w_beat     = bus.in_valid & w_in_ready;
  assign w_last     = (r_count == CNT_W'(N_TERMS - 1));
  // Extra top bit of the sum is the carry-out that sets overflow.
  assign w_sum      = {1'b0, r_acc} + SUM_W'(w_prod);

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_acc_nxt      = '0;
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
          w_state_nxt    = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_beat) begin
          w_acc_nxt      = w_sum[ACC_W-1:0];
          w_overflow_nxt = r_overflow | w_sum[ACC_W];
          w_count_nxt    = r_count + CNT_W'(1);
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
      r_busy     <= (w_state_nxt == ST_ACCUM);
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.acc      = r_acc;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_overflow;

endmodule : mult_accumulator

// File: tb/tb_mult_accumulator.sv
// Directed bench: three accumulator configurations driven with hand-computed vectors.
module tb_mult_accumulator;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mult_accumulator_if #(.ACC_W(8)) ifa ();
  mult_accumulator_if #(.ACC_W(4)) ifb ();
  mult_accumulator_if #(.ACC_W(8)) ifc ();

  mult_accumulator #(.N_TERMS(4), .ACC_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mult_accumulator #(.N_TERMS(2), .ACC_W(4)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  mult_accumulator #(.N_TERMS(1), .ACC_W(8)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operand table shared by the four-term scenarios: (3,3),(2,1),(1,3),(0,2).
  logic [1:0] va [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
  logic [1:0] vb [4] = '{2'd3, 2'd1, 2'd3, 2'd2};
  logic [7:0] vacc [4] = '{8'd9, 8'd11, 8'd14, 8'd14};

  task automatic start_a();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (ifa.acc !== 8'd0) begin errors++; $display("FAIL rst_acc got %0d exp 0", ifa.acc); end
    checks++; if ({ifa.busy, ifa.done, ifa.overflow, ifa.in_ready} !== 4'b0000) begin errors++;
      $display("FAIL rst_flags got %b exp 0000", {ifa.busy, ifa.done, ifa.overflow, ifa.in_ready}); end
    checks++; if ({ifb.acc, ifb.busy, ifb.done, ifb.overflow, ifb.in_ready} !== 8'd0) begin errors++;
      $display("FAIL rst_b got %b exp 0", {ifb.acc, ifb.busy, ifb.done, ifb.overflow, ifb.in_ready}); end
  endtask

  task automatic test_back_to_back();
    start_a();
    checks++; if ({ifa.busy, ifa.in_ready, ifa.done} !== 3'b110) begin errors++;
      $display("FAIL b2b_accum_flags got %b exp 110", {ifa.busy, ifa.in_ready, ifa.done}); end
    for (int i = 0; i < 4; i++) begin
      ifa.a = va[i]; ifa.b = vb[i]; ifa.in_valid = 1'b1;
      tick();
      checks++; if (ifa.acc !== vacc[i]) begin errors++; $display("FAIL b2b_acc%0d got %0d exp %0d", i, ifa.acc, vacc[i]); end
      if (i < 3) begin
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL b2b_early_done%0d got %b exp 0", i, ifa.done); end
      end
    end
    ifa.in_valid = 1'b0;
    checks++; if ({ifa.done, ifa.in_ready, ifa.busy, ifa.overflow} !== 4'b1000) begin errors++;
      $display("FAIL b2b_done_flags got %b exp 1000", {ifa.done, ifa.in_ready, ifa.busy, ifa.overflow}); end
    tick();
    checks++; if ({ifa.done, ifa.acc} !== {1'b0, 8'd14}) begin errors++;
      $display("FAIL b2b_idle got done=%b acc=%0d exp done=0 acc=14", ifa.done, ifa.acc); end
  endtask

  task automatic test_gaps();
    start_a();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        ifa.in_valid = 1'b0; ifa.a = 2'd3; ifa.b = 2'd3;
        for (int g = 0; g < 2; g++) begin
          tick();
          checks++; if ({ifa.done, ifa.acc} !== {1'b0, vacc[i-1]}) begin errors++;
            $display("FAIL gap%0d_%0d got done=%b acc=%0d exp done=0 acc=%0d", i, g, ifa.done, ifa.acc, vacc[i-1]); end
        end
      end
      ifa.a = va[i]; ifa.b = vb[i]; ifa.in_valid = 1'b1;
      tick();
      checks++; if (ifa.acc !== vacc[i]) begin errors++; $display("FAIL gap_acc%0d got %0d exp %0d", i, ifa.acc, vacc[i]); end
    end
    ifa.in_valid = 1'b0;
    checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL gap_done got %b exp 1", ifa.done); end
    tick();
  endtask

  task automatic test_overflow();
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    ifb.a = 2'd3; ifb.b = 2'd3; ifb.in_valid = 1'b1;
    tick();
    checks++; if ({ifb.acc, ifb.overflow} !== {4'd9, 1'b0}) begin errors++;
      $display("FAIL ovf_beat0 got acc=%0d ovf=%b exp acc=9 ovf=0", ifb.acc, ifb.overflow); end
    tick();
    ifb.in_valid = 1'b0;
    checks++; if ({ifb.acc, ifb.overflow, ifb.done} !== {4'd2, 1'b1, 1'b1}) begin errors++;
      $display("FAIL ovf_wrap got acc=%0d ovf=%b done=%b exp acc=2 ovf=1 done=1", ifb.acc, ifb.overflow, ifb.done); end
    tick();
    tick();
    checks++; if ({ifb.acc, ifb.overflow} !== {4'd2, 1'b1}) begin errors++;
      $display("FAIL ovf_sticky got acc=%0d ovf=%b exp acc=2 ovf=1", ifb.acc, ifb.overflow); end
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    checks++; if ({ifb.acc, ifb.overflow, ifb.busy} !== {4'd0, 1'b0, 1'b1}) begin errors++;
      $display("FAIL ovf_clear got acc=%0d ovf=%b busy=%b exp acc=0 ovf=0 busy=1", ifb.acc, ifb.overflow, ifb.busy); end
    ifb.a = 2'd1; ifb.b = 2'd2; ifb.in_valid = 1'b1;
    tick(); tick();
    ifb.in_valid = 1'b0;
    checks++; if ({ifb.acc, ifb.overflow, ifb.done} !== {4'd4, 1'b0, 1'b1}) begin errors++;
      $display("FAIL ovf_after got acc=%0d ovf=%b done=%b exp acc=4 ovf=0 done=1", ifb.acc, ifb.overflow, ifb.done); end
    tick();
  endtask

  task automatic test_start_ignored();
    start_a();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        ifa.in_valid = 1'b0; ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        checks++; if ({ifa.busy, ifa.acc} !== {1'b1, 8'd11}) begin errors++;
          $display("FAIL stign_hold got busy=%b acc=%0d exp busy=1 acc=11", ifa.busy, ifa.acc); end
      end
      ifa.a = va[i]; ifa.b = vb[i]; ifa.in_valid = 1'b1;
      tick();
    end
    ifa.in_valid = 1'b0;
    checks++; if ({ifa.done, ifa.acc} !== {1'b1, 8'd14}) begin errors++;
      $display("FAIL stign_done got done=%b acc=%0d exp done=1 acc=14", ifa.done, ifa.acc); end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [1:0] ra [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic [1:0] rb [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
    start_a();
    for (int i = 0; i < 2; i++) begin
      ifa.a = va[i]; ifa.b = vb[i]; ifa.in_valid = 1'b1;
      tick();
    end
    ifa.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ifa.acc, ifa.busy, ifa.in_ready} !== {8'd0, 1'b0, 1'b0}) begin errors++;
      $display("FAIL abort_now got acc=%0d busy=%b rdy=%b exp 0 0 0", ifa.acc, ifa.busy, ifa.in_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL abort_nodone%0d got %b exp 0", i, ifa.done); end
    end
    #2 rst_n = 1'b1;
    tick();
    checks++; if ({ifa.done, ifa.busy} !== 2'b00) begin errors++;
      $display("FAIL abort_idle got done=%b busy=%b exp 0 0", ifa.done, ifa.busy); end
    start_a();
    for (int i = 0; i < 4; i++) begin
      ifa.a = ra[i]; ifa.b = rb[i]; ifa.in_valid = 1'b1;
      tick();
    end
    ifa.in_valid = 1'b0;
    checks++; if ({ifa.done, ifa.acc, ifa.overflow} !== {1'b1, 8'd10, 1'b0}) begin errors++;
      $display("FAIL abort_fresh got done=%b acc=%0d ovf=%b exp 1 10 0", ifa.done, ifa.acc, ifa.overflow); end
    tick();
  endtask

  task automatic test_single_term();
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    ifc.a = 2'd2; ifc.b = 2'd3; ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    checks++; if ({ifc.acc, ifc.done, ifc.in_ready} !== {8'd6, 1'b1, 1'b0}) begin errors++;
      $display("FAIL n1_done got acc=%0d done=%b rdy=%b exp 6 1 0", ifc.acc, ifc.done, ifc.in_ready); end
    tick();
    tick();
    checks++; if ({ifc.acc, ifc.done, ifc.busy} !== {8'd6, 1'b0, 1'b0}) begin errors++;
      $display("FAIL n1_idle got acc=%0d done=%b busy=%b exp 6 0 0", ifc.acc, ifc.done, ifc.busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    {ifa.start, ifa.in_valid, ifa.a, ifa.b} = '0;
    {ifb.start, ifb.in_valid, ifb.a, ifb.b} = '0;
    {ifc.start, ifc.in_valid, ifc.a, ifc.b} = '0;
    tick();
    tick();
    test_reset();
    #2 rst_n = 1'b1;
    tick();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_start_ignored();
    test_reset_abort();
    test_single_term();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mult_accumulator
